mpx_hilo_ctrl: RTL and testbench
================================

// Module: mpx_hilo_ctrl
// PURPOSE
//  Sequences the shared mult/div unit and owns the architectural HI/LO registers.
//  - Accepts decoded HI/LO-class ops from the issue stage.
//  - Starts the divider (1-cycle start pulse, result 34 cycles later) or the multiplier.
//  - Keeps ownership of the single pending result and drops stale writebacks.
//  - Interlocks MFHI/MFLO/MTHI/MTLO against pending results.
// PARAMETERS
//  MUL_MAX_OUTSTANDING  3  maximum multiplier results in flight; issue stalls beyond this
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   asynchronous reset, active high
//  issue_valid_i     in   1   op presented
//  issue_op_i        in   4   hilo_op_t: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
//  issue_rs_i        in   32  rs operand (dividend, multiplicand, MTxx data)
//  issue_rt_i        in   32  rt operand
//  issue_ready_o     out  1   op accepted this cycle when valid&ready
//  div_start_o       out  1   one-cycle start pulse to divider (carries DIV/DIVU opcode)
//  mul_start_o       out  1   one-cycle start pulse to multiplier
//  div_valid_i       in   1   divider writeback strobe
//  div_hi_i/div_lo_i in   32  divider remainder/quotient
//  mul_valid_i       in   1   multiplier writeback strobe
//  mul_hi_i/mul_lo_i in   32  product halves
//  mf_valid_o        out  1   MFHI/MFLO result valid (same cycle as acceptance)
//  mf_data_o         out  32  HI or LO value
//  busy_o            out  1   result pending (state != IDLE)
// BEHAVIOUR
//  - Reset (async): state=IDLE; HI=LO=0; owner=NONE; mul_cnt=0.
//    All outputs 0, except issue_ready_o=1.
//  - States:
//    - IDLE: no result pending.
//    - DIV_PEND: divider result owned.
//    - MUL_PEND: multiplier result owned.
//  - MULT/MULTU/DIV/DIVU:
//    - Always ready, except a MULT* when mul_cnt==MUL_MAX_OUTSTANDING.
//    - On accept: pulse the start output for exactly 1 cycle, go to *_PEND and switch owner.
//    - MULT* increments mul_cnt.
//  - MTHI/MTLO: ready only in IDLE. Write HI/LO at the clock edge of acceptance.
//  - MFHI/MFLO: ready only in IDLE. mf_valid_o=1 and mf_data_o=HI/LO combinationally in the accept cycle.
//  - Divider writeback:
//    - div_valid_i in DIV_PEND: load HI<=div_hi_i and LO<=div_lo_i, then go to IDLE.
//    - div_valid_i in any other state is dropped.
//  - Multiplier writeback:
//    - Every mul_valid_i decrements mul_cnt.
//    - It loads HI/LO and goes to IDLE only in MUL_PEND with mul_cnt==1.
//    - Otherwise it is dropped (superseded).
//  - Simultaneous events:
//    - A new MULT*/DIV* accepted in the same cycle as a writeback: the new op wins, the writeback is dropped. mul_cnt decrement and increment net to zero.
//    - An MF*/MT* cannot be accepted in the same cycle as a writeback (not IDLE). Earliest acceptance is the cycle after the writeback.
//  - A divider restart on a new DIV supersedes the old DIV. Exactly one div_valid_i follows.
//  - Reset mid-operation: state is discarded. Late writebacks arriving after reset are dropped (owner=NONE).
//  - Divider reference latency: start at cycle T, div_valid_i at T+34. The controller is latency-agnostic.
// CONFIGURATION
//  MPX_HILO_DIV0_FAST_EN
//  - Defined: DIV/DIVU with rt==0 does not pulse div_start_o.
//    - Next cycle load HI=rs.
//    - DIVU: LO=32'hFFFFFFFF.
//    - DIV: LO = rs[31] ? 32'h1 : 32'hFFFFFFFF.
//    - Pass through 1 cycle of DIV_PEND. Results are bit-identical to the divider.
//  - Undefined: rt==0 is sent to the divider like any other divide.
// STRUCTURE
//  - mpx_defs package: hilo_op_t encoding, state encoding (IDLE/DIV_PEND/MUL_PEND), owner encoding.
//  - No sub-module: single FSM plus HI/LO registers and the mul_cnt counter.
// TESTING
//  1. DIVU rs=100 rt=7: div_start_o pulses once. MFLO is stalled until HI=2, LO=14 are loaded, then returns 14 with busy_o=0.
//  2. DIV 100/7, then MULTU 3*5 two cycles later: stale div_valid_i is dropped; HI=0, LO=15.
//  3. MULT 2*3, MULT 4*5, MULT 6*7 back-to-back (MUL_MAX_OUTSTANDING=3):
//     - The fourth MULT stalls until the first writeback.
//     - Only the last product loads: LO=42.
//  4. MTHI 0xDEADBEEF issued while DIV is pending: issue_ready_o=0 until the writeback. HI then becomes 0xDEADBEEF.
//  5. DIV rs=-5 rt=0:
//     - Result is HI=0xFFFFFFFB, LO=0x00000001.
//     - With MPX_HILO_DIV0_FAST_EN: no div_start_o pulse, busy_o for 1 cycle.
//  6. rst_i asserted 10 cycles into a DIV: outputs return to reset values immediately. The late div_valid_i is dropped; HI=LO=0.

Source files
------------

// File: rtl/mpx_defs_pkg.sv
// Shared encodings for the HI/LO controller: issue opcodes, FSM states, result owner.
package mpx_defs;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_PEND = 2'd1,
    ST_MUL_PEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DIV  = 2'd1,
    OWN_MUL  = 2'd2
  } owner_t;

  // Quotient the divider produces for a zero divisor (the remainder is the dividend).
  function automatic logic [31:0] div0_quotient(input logic is_signed, input logic [31:0] rs);
    return (is_signed && rs[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/mpx_hilo_ctrl.sv
// Mult/div sequencer owning the HI/LO registers, tracking the single live result.
// Build option MPX_HILO_DIV0_FAST_EN resolves divide-by-zero locally without the divider.
module mpx_hilo_ctrl
  import mpx_defs::*;
#(
  parameter int MUL_MAX_OUTSTANDING = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [3:0]  issue_op_i,
  input  logic [31:0] issue_rs_i,
  input  logic [31:0] issue_rt_i,
  output logic        issue_ready_o,
  output logic        div_start_o,
  output logic        mul_start_o,
  input  logic        div_valid_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  input  logic        mul_valid_i,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i,
  output logic        mf_valid_o,
  output logic [31:0] mf_data_o,
  output logic        busy_o
);

  localparam int CW = $clog2(MUL_MAX_OUTSTANDING + 1);

  hilo_op_t       op;
  state_t         state_reg, state_next;
  owner_t         owner_reg, owner_next;
  logic [31:0]    hi_reg, hi_next;
  logic [31:0]    lo_reg, lo_next;
  logic [CW-1:0]  mul_cnt_reg, mul_cnt_next;

  logic is_mul, is_div, is_mt, is_mf, accept;
  logic mul_dec, mul_take, div_take;
  logic div0_fast, fast_wb;
  logic [31:0] fast_hi, fast_lo;

  assign op     = hilo_op_t'(issue_op_i);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
  assign is_mf  = (op == OP_MFHI) || (op == OP_MFLO);

  always_comb begin
    issue_ready_o = 1'b1;
    if (is_mul && (mul_cnt_reg == CW'(MUL_MAX_OUTSTANDING)))
      issue_ready_o = 1'b0;
    if ((is_mt || is_mf) && (state_reg != ST_IDLE))
      issue_ready_o = 1'b0;
  end

  assign accept      = issue_valid_i && issue_ready_o;
  assign div_start_o = accept && is_div && !div0_fast;
  assign mul_start_o = accept && is_mul;
  assign mf_valid_o  = accept && is_mf;
  assign mf_data_o   = mf_valid_o ? ((op == OP_MFHI) ? hi_reg : lo_reg) : '0;
  assign busy_o      = (state_reg != ST_IDLE);

`ifdef MPX_HILO_DIV0_FAST_EN
  logic        fast_pend_reg;
  logic [31:0] fast_hi_reg, fast_lo_reg;

  assign div0_fast = is_div && (issue_rt_i == 32'd0);

  // Zero-divisor result is staged for one cycle so timing still looks like a (short) divide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fast_pend_reg <= 1'b0;
      fast_hi_reg   <= '0;
      fast_lo_reg   <= '0;
    end else begin
      fast_pend_reg <= accept && div0_fast;
      if (accept && div0_fast) begin
        fast_hi_reg <= issue_rs_i;
        fast_lo_reg <= div0_quotient(op == OP_DIV, issue_rs_i);
      end
    end
  end

  assign fast_wb = fast_pend_reg;
  assign fast_hi = fast_hi_reg;
  assign fast_lo = fast_lo_reg;
`else
  // rt only matters to the local divide-by-zero path.
  logic unused_rt;
  assign unused_rt = ^issue_rt_i;
  assign div0_fast = 1'b0;
  assign fast_wb   = 1'b0;
  assign fast_hi   = '0;
  assign fast_lo   = '0;
`endif

  assign mul_dec  = mul_valid_i && (mul_cnt_reg != '0);
  assign mul_take = mul_valid_i && (state_reg == ST_MUL_PEND) && (owner_reg == OWN_MUL)
                    && (mul_cnt_reg == CW'(1));
  assign div_take = div_valid_i && (state_reg == ST_DIV_PEND) && (owner_reg == OWN_DIV);

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    mul_cnt_next = mul_cnt_reg;

    if (mul_start_o && !mul_dec)
      mul_cnt_next = mul_cnt_reg + CW'(1);
    else if (!mul_start_o && mul_dec)
      mul_cnt_next = mul_cnt_reg - CW'(1);

    // A newly accepted mult/div takes ownership and outranks any same-cycle writeback.
    if (accept && (is_mul || is_div)) begin
      state_next = is_mul ? ST_MUL_PEND : ST_DIV_PEND;
      owner_next = is_mul ? OWN_MUL : OWN_DIV;
    end else if (accept && (op == OP_MTHI)) begin
      hi_next = issue_rs_i;
    end else if (accept && (op == OP_MTLO)) begin
      lo_next = issue_rs_i;
    end else if (fast_wb) begin
      hi_next    = fast_hi;
      lo_next    = fast_lo;
      state_next = ST_IDLE;
      owner_next = OWN_NONE;
    end else if (div_take) begin
      hi_next    = div_hi_i;
      lo_next    = div_lo_i;
      state_next = ST_IDLE;
      owner_next = OWN_NONE;
    end else if (mul_take) begin
      hi_next    = mul_hi_i;
      lo_next    = mul_lo_i;
      state_next = ST_IDLE;
      owner_next = OWN_NONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWN_NONE;
      hi_reg      <= '0;
      lo_reg      <= '0;
      mul_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

endmodule

// File: tb/tb_mpx_hilo_ctrl.sv
// Directed bench for mpx_hilo_ctrl with behavioural divider (34-cycle) and pipelined multiplier.
module tb_mpx_hilo_ctrl;
  import mpx_defs::*;

  localparam int MUL_LAT = 8;
  localparam int DIV_LAT = 34;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [3:0]  issue_op_i = 4'd0;
  logic [31:0] issue_rs_i = '0;
  logic [31:0] issue_rt_i = '0;
  logic        issue_ready_o, div_start_o, mul_start_o;
  logic        div_valid_i = 1'b0;
  logic [31:0] div_hi_i = '0, div_lo_i = '0;
  logic        mul_valid_i = 1'b0;
  logic [31:0] mul_hi_i = '0, mul_lo_i = '0;
  logic        mf_valid_o, busy_o;
  logic [31:0] mf_data_o;

  int checks = 0;
  int fails  = 0;
  int dstart_cnt = 0;
  int mstart_cnt = 0;
  logic last_mfv, last_busy;

  typedef struct {
    int          cnt;
    logic [31:0] hi;
    logic [31:0] lo;
  } mul_job_t;
  mul_job_t mq[$];

  mpx_hilo_ctrl #(.MUL_MAX_OUTSTANDING(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i),
    .issue_rs_i(issue_rs_i), .issue_rt_i(issue_rt_i), .issue_ready_o(issue_ready_o),
    .div_start_o(div_start_o), .mul_start_o(mul_start_o),
    .div_valid_i(div_valid_i), .div_hi_i(div_hi_i), .div_lo_i(div_lo_i),
    .mul_valid_i(mul_valid_i), .mul_hi_i(mul_hi_i), .mul_lo_i(mul_lo_i),
    .mf_valid_o(mf_valid_o), .mf_data_o(mf_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Execution-unit models: a restartable divider and an in-order multiplier pipe, not reset with the DUT.
  initial begin : units
    int dcnt;
    int a, b;
    logic [31:0] dq_hi, dq_lo;
    logic [63:0] p;
    mul_job_t job;
    dcnt = 0; dq_hi = '0; dq_lo = '0;
    forever begin
      @(negedge clk_i);
      div_valid_i = 1'b0;
      mul_valid_i = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_valid_i = 1'b1; div_hi_i = dq_hi; div_lo_i = dq_lo;
        end
      end
      if (div_start_o) begin
        dstart_cnt++;
        dcnt = DIV_LAT;
        if (issue_rt_i == 32'd0) begin
          dq_hi = issue_rs_i;
          dq_lo = (issue_op_i == OP_DIV && issue_rs_i[31]) ? 32'h1 : 32'hFFFF_FFFF;
        end else if (issue_op_i == OP_DIVU) begin
          dq_lo = issue_rs_i / issue_rt_i;
          dq_hi = issue_rs_i % issue_rt_i;
        end else begin
          a = issue_rs_i; b = issue_rt_i;
          dq_lo = a / b;
          dq_hi = a % b;
        end
      end
      foreach (mq[i]) mq[i].cnt--;
      if (mq.size() > 0 && mq[0].cnt == 0) begin
        mul_valid_i = 1'b1; mul_hi_i = mq[0].hi; mul_lo_i = mq[0].lo;
        void'(mq.pop_front());
      end
      if (mul_start_o) begin
        mstart_cnt++;
        if (issue_op_i == OP_MULT)
          p = {{32{issue_rs_i[31]}}, issue_rs_i} * {{32{issue_rt_i[31]}}, issue_rt_i};
        else
          p = {32'd0, issue_rs_i} * {32'd0, issue_rt_i};
        job.cnt = MUL_LAT; job.hi = p[63:32]; job.lo = p[31:0];
        mq.push_back(job);
      end
    end
  end

  // Present one op, hold it until accepted; stalls = cycles spent not ready.
  task automatic issue(input hilo_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls, output logic [31:0] mfd);
    @(posedge clk_i); #1;
    issue_valid_i = 1'b1; issue_op_i = op; issue_rs_i = rs; issue_rt_i = rt;
    stalls = 0;
    forever begin
      @(negedge clk_i);
      if (issue_ready_o) break;
      stalls++;
      if (stalls > 200) begin
        checks++; fails++;
        $display("FAIL issue_timeout op=%0d still not ready after %0d cycles", op, stalls);
        break;
      end
    end
    mfd = mf_data_o; last_mfv = mf_valid_o; last_busy = busy_o;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; issue_op_i = OP_NONE;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk_i);
    while (busy_o) begin
      cycles++;
      if (cycles > 200) begin
        checks++; fails++;
        $display("FAIL idle_timeout busy_o still 1 after %0d cycles", cycles);
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    int st;
    issue(OP_MFHI, 32'd0, 32'd0, st, hi);
    issue(OP_MFLO, 32'd0, 32'd0, st, lo);
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    logic [31:0] hi, lo;
    #1;
    obs = {issue_ready_o, busy_o, div_start_o, mul_start_o, mf_valid_o, mf_data_o};
    checks++;
    if (obs !== {5'b10000, 32'd0}) begin
      fails++; $display("FAIL reset_outputs got %h want %h", obs, {5'b10000, 32'd0});
    end
    @(negedge clk_i); rst_i = 1'b0;
    read_hilo(hi, lo);
    checks++;
    if (last_mfv !== 1'b1) begin fails++; $display("FAIL reset_mf_valid got %b want 1", last_mfv); end
    checks++;
    if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    $display("test_reset: HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_divu();
    int st, d0;
    logic [31:0] v, hi;
    d0 = dstart_cnt;
    issue(OP_DIVU, 32'd100, 32'd7, st, v);
    issue(OP_MFLO, 32'd0, 32'd0, st, v);
    checks++;
    if (st !== 33) begin fails++; $display("FAIL divu_mflo_stall got %0d want 33", st); end
    checks++;
    if (v !== 32'd14 || last_busy !== 1'b0) begin
      fails++; $display("FAIL divu_mflo got %0d busy=%b want 14 busy=0", v, last_busy);
    end
    issue(OP_MFHI, 32'd0, 32'd0, st, hi);
    checks++;
    if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi got %0d want 2", hi); end
    checks++;
    if (dstart_cnt - d0 !== 1) begin fails++; $display("FAIL divu_start_pulses got %0d want 1", dstart_cnt - d0); end
    $display("test_divu: LO=%0d HI=%0d stall=%0d", v, hi, st);
  endtask

  task automatic test_stale_div();
    int st, cyc;
    logic [31:0] v, hi, lo;
    issue(OP_DIV, 32'd100, 32'd7, st, v);
    issue(OP_MULTU, 32'd3, 32'd5, st, v);
    wait_idle(cyc);
    repeat (40) @(posedge clk_i);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      fails++; $display("FAIL stale_div_hilo got %h/%h want 0/f", hi, lo);
    end
    $display("test_stale_div: HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_mul();
    int st, cyc, m0;
    logic [31:0] v, hi, lo;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, st, v);
    wait_idle(cyc);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      fails++; $display("FAIL mult_signed got %h/%h want ffffffff/fffffff1", hi, lo);
    end
    m0 = mstart_cnt;
    issue(OP_MULT, 32'd2, 32'd3, st, v);
    issue(OP_MULT, 32'd4, 32'd5, st, v);
    issue(OP_MULT, 32'd6, 32'd7, st, v);
    checks++;
    if (st !== 0) begin fails++; $display("FAIL mult_third_stall got %0d want 0", st); end
    issue(OP_MULT, 32'd6, 32'd7, st, v);
    checks++;
    if (st !== 3) begin fails++; $display("FAIL mult_fourth_stall got %0d want 3", st); end
    wait_idle(cyc);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin fails++; $display("FAIL mult_last_wins got %h/%h want 0/2a", hi, lo); end
    checks++;
    if (mstart_cnt - m0 !== 4) begin fails++; $display("FAIL mult_start_pulses got %0d want 4", mstart_cnt - m0); end
    $display("test_mul: HI=%h LO=%h fourth_stall=%0d", hi, lo, st);
  endtask

  task automatic test_mthi_interlock();
    int st;
    logic [31:0] v, hi, lo;
    issue(OP_DIV, 32'd100, 32'd7, st, v);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, st, v);
    checks++;
    if (st !== 33) begin fails++; $display("FAIL mthi_stall got %0d want 33", st); end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'd14) begin
      fails++; $display("FAIL mthi_hilo got %h/%h want deadbeef/e", hi, lo);
    end
    $display("test_mthi_interlock: HI=%h LO=%h stall=%0d", hi, lo, st);
  endtask

  task automatic test_div0();
    int st, cyc, d0, exp_starts, exp_busy;
    logic [31:0] v, hi, lo;
`ifdef MPX_HILO_DIV0_FAST_EN
    exp_starts = 0; exp_busy = 1;
`else
    exp_starts = 1; exp_busy = DIV_LAT;
`endif
    d0 = dstart_cnt;
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, st, v);
    wait_idle(cyc);
    checks++;
    if (cyc !== exp_busy) begin fails++; $display("FAIL div0_busy_cycles got %0d want %0d", cyc, exp_busy); end
    checks++;
    if (dstart_cnt - d0 !== exp_starts) begin
      fails++; $display("FAIL div0_start_pulses got %0d want %0d", dstart_cnt - d0, exp_starts);
    end
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'hFFFF_FFFB || lo !== 32'h0000_0001) begin
      fails++; $display("FAIL div0_signed got %h/%h want fffffffb/00000001", hi, lo);
    end
    issue(OP_DIVU, 32'd9, 32'd0, st, v);
    wait_idle(cyc);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div0_unsigned got %h/%h want 9/ffffffff", hi, lo);
    end
    $display("test_div0: HI=%h LO=%h busy=%0d", hi, lo, cyc);
  endtask

  task automatic test_restart();
    int st, cyc, d0;
    logic [31:0] v, hi, lo;
    d0 = dstart_cnt;
    issue(OP_DIV, 32'd100, 32'd7, st, v);
    issue(OP_DIVU, 32'd50, 32'd8, st, v);
    wait_idle(cyc);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd6) begin fails++; $display("FAIL restart_hilo got %h/%h want 2/6", hi, lo); end
    checks++;
    if (dstart_cnt - d0 !== 2) begin fails++; $display("FAIL restart_pulses got %0d want 2", dstart_cnt - d0); end
    $display("test_restart: HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_back_to_back();
    int st, cyc;
    logic [31:0] v, hi, lo;
    issue(OP_MULT, 32'd2, 32'd3, st, v);
    repeat (6) @(posedge clk_i);
    issue(OP_DIV, 32'd100, 32'd7, st, v);
    checks++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL wb_collision_busy got %b want 1", busy_o); end
    wait_idle(cyc);
    read_hilo(hi, lo);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin fails++; $display("FAIL wb_collision_hilo got %h/%h want 2/e", hi, lo); end
    $display("test_back_to_back: HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_reset_mid();
    int st;
    logic [31:0] v, hi, lo;
    logic [36:0] obs;
    issue(OP_DIV, 32'd100, 32'd7, st, v);
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    obs = {issue_ready_o, busy_o, div_start_o, mul_start_o, mf_valid_o, mf_data_o};
    checks++;
    if (obs !== {5'b10000, 32'd0}) begin
      fails++; $display("FAIL midreset_outputs got %h want %h", obs, {5'b10000, 32'd0});
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    read_hilo(hi, lo);
    checks++;
    if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
    $display("test_reset_mid: HI=%h LO=%h", hi, lo);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    test_reset();
    test_divu();
    test_stale_div();
    test_mul();
    test_mthi_interlock();
    test_div0();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
